// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the execute-stage sequencer and anything else that
//   needs to classify a funct code (for example the hazard unit):
//     - funct code constants for every supported operation
//     - opClass_t : which execute unit (or result path) a funct belongs to
//     - seqState_t: sequencer state encoding
//     - MUX_*     : result-mux select values
//     - classify(): funct -> opClass_t
package alu_pkg;

  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_SHT,
    CLS_MUL,
    CLS_DIV,
    CLS_MFHI,
    CLS_MFLO,
    CLS_ILL
  } opClass_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WAIT_MUL,
    WAIT_DIV
  } seqState_t;

  localparam logic [1:0] MUX_ALU = 2'd0;
  localparam logic [1:0] MUX_SHT = 2'd1;
  localparam logic [1:0] MUX_HI  = 2'd2;
  localparam logic [1:0] MUX_LO  = 2'd3;

  function automatic opClass_t classify(input logic [5:0] f);
    opClass_t c;
    case (f)
      FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT: c = CLS_ALU;
      FN_SRL:                                c = CLS_SHT;
      FN_MULTU:                              c = CLS_MUL;
      FN_DIVU:                               c = CLS_DIV;
      FN_MFHI:                               c = CLS_MFHI;
      FN_MFLO:                               c = CLS_MFLO;
      default:                               c = CLS_ILL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_funct_decode.sv
// alu_funct_decode
//   Purely combinational funct -> operation-class decoder.
//   Ports:
//     funct   in  6  operation code
//     opClass out 3  opClass_t encoding of the class the code belongs to
module alu_funct_decode
  import alu_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] opClass
);

  assign opClass = 3'(classify(funct));

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Execute-stage sequencer. Accepts one funct per request, drives the op
//   select bus of the unit that executes it, and reports completion.
//   Single-cycle ops (ALU, SRL, MFHI, MFLO) and illegal codes complete in the
//   cycle after start is sampled. MULTU/DIVU pulse the unit's start strobe and
//   then wait for its done, giving up after TIMEOUT cycles.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     start, funct          request and operation code (sampled in IDLE only)
//     busy                  high in any state other than IDLE
//     done                  one-cycle completion pulse
//     illegal, err          completion qualifiers (undecodable / unit timeout)
//     alu_op/sht_op/mul_op/div_op  funct routed to the selected unit, else 0
//     mul_start, div_start  one-cycle unit start strobes
//     mul_done, div_done    unit completion inputs
//     hilo_we               HI/LO write enable (same cycle as unit done)
//     mux_sel               result select: 0 ALU, 1 SHT, 2 HI, 3 LO
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int TIMEOUT = 40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [5:0] funct,
  output logic       busy,
  output logic       done,
  output logic       illegal,
  output logic       err,
  output logic [5:0] alu_op,
  output logic [5:0] sht_op,
  output logic [5:0] mul_op,
  output logic [5:0] div_op,
  output logic       mul_start,
  output logic       div_start,
  input  logic       mul_done,
  input  logic       div_done,
  output logic       hilo_we,
  output logic [1:0] mux_sel
);

  localparam logic [5:0] CNT_LAST = 6'(TIMEOUT - 1);

  seqState_t  state;
  logic [5:0] functQ;
  logic [5:0] cnt;

  logic [5:0] aluOpQ;
  logic [5:0] shtOpQ;
  logic [5:0] mulOpQ;
  logic [5:0] divOpQ;
  logic [1:0] muxSelQ;
  logic       doneQ;
  logic       illegalQ;
  logic       mulStartQ;
  logic       divStartQ;

  // The incoming code is decoded so the EXEC-cycle outputs can be registered
  // at the accepting edge; the captured code is decoded to steer EXEC.
  logic [2:0] newClassRaw;
  logic [2:0] heldClassRaw;
  opClass_t   newClass;
  opClass_t   heldClass;

  alu_funct_decode uNewDecode (
    .funct  (funct),
    .opClass(newClassRaw)
  );

  alu_funct_decode uHeldDecode (
    .funct  (functQ),
    .opClass(heldClassRaw)
  );

  assign newClass  = opClass_t'(newClassRaw);
  assign heldClass = opClass_t'(heldClassRaw);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      functQ    <= '0;
      cnt       <= '0;
      aluOpQ    <= '0;
      shtOpQ    <= '0;
      mulOpQ    <= '0;
      divOpQ    <= '0;
      muxSelQ   <= MUX_ALU;
      doneQ     <= 1'b0;
      illegalQ  <= 1'b0;
      mulStartQ <= 1'b0;
      divStartQ <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            functQ  <= funct;
            state   <= EXEC;
            // mul/div/illegal leave the result mux on ALU
            muxSelQ <= MUX_ALU;
            case (newClass)
              CLS_ALU: begin
                aluOpQ <= funct;
                doneQ  <= 1'b1;
              end
              CLS_SHT: begin
                shtOpQ  <= funct;
                muxSelQ <= MUX_SHT;
                doneQ   <= 1'b1;
              end
              CLS_MFHI: begin
                muxSelQ <= MUX_HI;
                doneQ   <= 1'b1;
              end
              CLS_MFLO: begin
                muxSelQ <= MUX_LO;
                doneQ   <= 1'b1;
              end
              CLS_MUL: begin
                mulOpQ    <= funct;
                mulStartQ <= 1'b1;
              end
              CLS_DIV: begin
                divOpQ    <= funct;
                divStartQ <= 1'b1;
              end
              default: begin
                doneQ    <= 1'b1;
                illegalQ <= 1'b1;
              end
            endcase
          end
        end

        EXEC: begin
          // Single-cycle results and start strobes last exactly this cycle;
          // mux_sel stays put so the result path remains selected in IDLE.
          doneQ     <= 1'b0;
          illegalQ  <= 1'b0;
          mulStartQ <= 1'b0;
          divStartQ <= 1'b0;
          aluOpQ    <= '0;
          shtOpQ    <= '0;
          cnt       <= '0;
          case (heldClass)
            CLS_MUL: state <= WAIT_MUL;
            CLS_DIV: state <= WAIT_DIV;
            default: state <= IDLE;
          endcase
        end

        WAIT_MUL: begin
          if (mul_done || cnt == CNT_LAST) begin
            state  <= IDLE;
            mulOpQ <= '0;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end

        WAIT_DIV: begin
          if (div_done || cnt == CNT_LAST) begin
            state  <= IDLE;
            divOpQ <= '0;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Completion of a multi-cycle op is flagged in the same cycle the unit
  // reports done, so these terms bypass the output registers. A unit done
  // arriving on the last counted cycle still counts as success.
  logic waitMul;
  logic waitDiv;
  logic unitDone;
  logic timedOut;

  assign waitMul  = (state == WAIT_MUL);
  assign waitDiv  = (state == WAIT_DIV);
  assign unitDone = (waitMul & mul_done) | (waitDiv & div_done);
  assign timedOut = (waitMul | waitDiv) & (cnt == CNT_LAST) & ~unitDone;

  assign busy      = (state != IDLE);
  assign done      = doneQ | unitDone | timedOut;
  assign illegal   = illegalQ;
  assign err       = timedOut;
  assign hilo_we   = unitDone;
  assign alu_op    = aluOpQ;
  assign sht_op    = shtOpQ;
  assign mul_op    = mulOpQ;
  assign div_op    = divOpQ;
  assign mul_start = mulStartQ;
  assign div_start = divStartQ;
  assign mux_sel   = muxSelQ;

endmodule
